// File: rtl/cordic_recon_top_level_if.sv
// Operand/result bundle for the reconfigurable CORDIC engine.
// All data fields are signed Q5.10; sel picks the CORDIC mode.
interface cordic_recon_top_level_if #(
    parameter int WIDTH = 15
);
    logic signed [WIDTH:0] Xo;
    logic signed [WIDTH:0] Yo;
    logic signed [WIDTH:0] Zo;
    logic        [1:0]     sel;
    logic signed [WIDTH:0] z;

    modport master (output Xo, Yo, Zo, sel, input z);
    modport slave  (input Xo, Yo, Zo, sel, output z);
endinterface

// File: rtl/cordic_recon_top_level.sv
// Iterative 16-step CORDIC core shared by circular, hyperbolic, linear-rotation
// and linear-vectoring modes; one result per reset, held until the next reset.
module cordic_recon_top_level #(
    parameter int WIDTH = 15
) (
    input  logic                      clk,
    input  logic                      ext_reset,
    cordic_recon_top_level_if.slave   bus
);
    localparam int IW    = WIDTH + 5;
    localparam int GUARD = IW - WIDTH - 1;

    typedef enum logic [1:0] {LOAD, ITER, DONE} state_t;
    typedef enum logic [1:0] {CIRC = 2'b00, HYPER = 2'b01, LIN_ROT = 2'b10, LIN_VEC = 2'b11} mode_t;

    state_t              state;
    mode_t               mode;
    logic        [3:0]   k;
    logic signed [IW-1:0] x;
    logic signed [IW-1:0] y;
    logic signed [IW-1:0] a;
    logic signed [WIDTH:0] z_reg;

    logic        [3:0]    s;
    logic signed [IW-1:0] x_sh;
    logic signed [IW-1:0] y_sh;
    logic signed [IW-1:0] e;
    logic                 d_pos;
    logic signed [IW-1:0] x_next;
    logic signed [IW-1:0] y_next;
    logic signed [IW-1:0] a_next;
    logic signed [11:0]   gain;
    logic signed [31:0]   prod;
    logic signed [31:0]   res;
    logic signed [WIDTH:0] res_sat;

    assign bus.z = z_reg;

    // Hyperbolic mode repeats shifts 4 and 13 so the series converges.
    always_comb begin
        s = k;
        if (mode == HYPER) begin
            if (k <= 4'd3)
                s = k + 4'd1;
            else if (k <= 4'd13)
                s = k;
            else
                s = k - 4'd1;
        end
    end

    always_comb begin
        e = '0;
        case (mode)
            CIRC: begin
                case (s)
                    4'd0:    e = IW'(804);
                    4'd1:    e = IW'(475);
                    4'd2:    e = IW'(251);
                    4'd3:    e = IW'(127);
                    4'd4:    e = IW'(64);
                    4'd5:    e = IW'(32);
                    4'd6:    e = IW'(16);
                    4'd7:    e = IW'(8);
                    4'd8:    e = IW'(4);
                    4'd9:    e = IW'(2);
                    4'd10:   e = IW'(1);
                    default: e = '0;
                endcase
            end
            HYPER: begin
                case (s)
                    4'd1:    e = IW'(562);
                    4'd2:    e = IW'(262);
                    4'd3:    e = IW'(129);
                    4'd4:    e = IW'(64);
                    4'd5:    e = IW'(32);
                    4'd6:    e = IW'(16);
                    4'd7:    e = IW'(8);
                    4'd8:    e = IW'(4);
                    4'd9:    e = IW'(2);
                    4'd10:   e = IW'(1);
                    default: e = '0;
                endcase
            end
            default: e = IW'(1024) >> s;
        endcase
    end

    always_comb begin
        x_sh   = x >>> s;
        y_sh   = y >>> s;
        d_pos  = (mode == LIN_VEC) ? (x[IW-1] ^ y[IW-1]) : ~a[IW-1];
        y_next = d_pos ? (y + x_sh) : (y - x_sh);
        a_next = d_pos ? (a - e) : (a + e);
        case (mode)
            CIRC:    x_next = d_pos ? (x - y_sh) : (x + y_sh);
            HYPER:   x_next = d_pos ? (x + y_sh) : (x - y_sh);
            default: x_next = x;
        endcase
    end

    // Gain compensation for the rotating modes, then clamp to 16 bits.
    always_comb begin
        gain = (mode == CIRC) ? 12'sd622 : 12'sd1236;
        prod = x * gain;
        case (mode)
            CIRC, HYPER: res = prod >>> 10;
            LIN_ROT:     res = {{(32-IW){y[IW-1]}}, y};
            default:     res = {{(32-IW){a[IW-1]}}, a};
        endcase
        if (res > 32'sd32767)
            res_sat = 16'sh7FFF;
        else if (res < -32'sd32768)
            res_sat = 16'sh8000;
        else
            res_sat = res[WIDTH:0];
    end

    always_ff @(posedge clk) begin
        if (!ext_reset) begin
            state <= LOAD;
            mode  <= CIRC;
            k     <= '0;
            x     <= '0;
            y     <= '0;
            a     <= '0;
            z_reg <= '0;
        end else begin
            case (state)
                LOAD: begin
                    mode  <= mode_t'(bus.sel);
                    x     <= {{GUARD{bus.Xo[WIDTH]}}, bus.Xo};
                    y     <= {{GUARD{bus.Yo[WIDTH]}}, bus.Yo};
                    a     <= {{GUARD{bus.Zo[WIDTH]}}, bus.Zo};
                    k     <= '0;
                    state <= ITER;
                end
                ITER: begin
                    x <= x_next;
                    y <= y_next;
                    a <= a_next;
                    k <= k + 4'd1;
                    if (k == 4'd15)
                        state <= DONE;
                end
                DONE: begin
                    z_reg <= res_sat;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_recon_top_level.sv
// Directed self-checking bench for cordic_recon_top_level: latency, modes,
// mid-run reset, operand latching and saturation.
module tb_cordic_recon_top_level;
    logic clk = 1'b0;
    logic ext_reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cordic_recon_top_level_if #(.WIDTH(15)) bus ();

    cordic_recon_top_level #(.WIDTH(15)) dut (
        .clk       (clk),
        .ext_reset (ext_reset),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected, input int tol);
        int diff;
        checks++;
        diff = observed - expected;
        if (diff > tol || diff < -tol) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", tag, observed, expected, tol);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] s, input int xv, input int yv, input int zv);
        bus.sel = s;
        bus.Xo  = 16'(xv);
        bus.Yo  = 16'(yv);
        bus.Zo  = 16'(zv);
    endtask

    // Reset for one edge with operands applied, release, then check busy/result/hold.
    task automatic runAndCheck(input string tag, input logic [1:0] s, input int xv, input int yv,
                               input int zv, input int expected, input int tol);
        @(negedge clk);
        ext_reset = 1'b0;
        applyStimulus(s, xv, yv, zv);
        @(posedge clk);
        #1 checkOutput({tag, "_rst"}, int'(bus.z), 0, 0);
        @(negedge clk);
        ext_reset = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            @(posedge clk);
            #1;
            if (e == 1 || e == 17)
                checkOutput({tag, "_busy"}, int'(bus.z), 0, 0);
        end
        @(posedge clk);
        #1 checkOutput(tag, int'(bus.z), expected, tol);
        repeat (3) @(posedge clk);
        #1 checkOutput({tag, "_hold"}, int'(bus.z), expected, tol);
    endtask

    initial begin
        $display("[TB] start");
        // Two reset cycles, then a linear-rotation run whose inputs change after LOAD.
        @(negedge clk);
        ext_reset = 1'b0;
        applyStimulus(2'b10, 128, -512, 1024);
        repeat (2) @(posedge clk);
        #1 checkOutput("reset_z", int'(bus.z), 0, 0);
        @(negedge clk);
        ext_reset = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            @(posedge clk);
            #1 checkOutput($sformatf("latency_e%0d", e), int'(bus.z), 0, 0);
            if (e == 1) begin
                @(negedge clk);
                applyStimulus(2'b00, 0, 0, 0);
            end
        end
        @(posedge clk);
        #1 checkOutput("lin_rot_e18", int'(bus.z), -384, 4);
        repeat (4) @(posedge clk);
        #1 checkOutput("lin_rot_hold", int'(bus.z), -384, 4);

        runAndCheck("circ_pi6",  2'b00, 1024,   0, 536,  887, 4);
        runAndCheck("circ_zero", 2'b00, 1024,   0,   0, 1024, 4);
        runAndCheck("hyp_half",  2'b01,  512, 512, 512,  844, 4);
        runAndCheck("hyp_zero",  2'b01,  512, 512,   0,  512, 4);
        runAndCheck("vec_neg",   2'b11,   64, -64, 288, -736, 4);
        runAndCheck("vec_pos",   2'b11,  512, 256,   0,  512, 4);

        // Abort a run at iteration 8 and restart with new operands.
        @(negedge clk);
        ext_reset = 1'b0;
        applyStimulus(2'b10, 128, -512, 1024);
        @(posedge clk);
        @(negedge clk);
        ext_reset = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        ext_reset = 1'b0;
        applyStimulus(2'b10, 512, 0, 512);
        @(posedge clk);
        #1 checkOutput("abort_z", int'(bus.z), 0, 0);
        @(negedge clk);
        ext_reset = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            @(posedge clk);
            #1;
            if (e == 17)
                checkOutput("abort_busy", int'(bus.z), 0, 0);
        end
        @(posedge clk);
        #1 checkOutput("abort_rerun", int'(bus.z), 256, 4);

        runAndCheck("sat_pos", 2'b10,  32767,  32767, 1536,  32767, 0);
        runAndCheck("sat_neg", 2'b10, -32768, -32768, 1536, -32768, 0);

        // Reset while holding a nonzero result must clear it.
        @(negedge clk);
        ext_reset = 1'b0;
        @(posedge clk);
        #1 checkOutput("done_reset", int'(bus.z), 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cordic_recon_top_level.md
Name: cordic_recon_top_level

Overview:
- Reconfigurable iterative CORDIC engine for the FPGA neural-network inference datapath.
- One shared shift-add core runs circular rotation, hyperbolic rotation, linear rotation (multiply-accumulate) or linear vectoring (divide-accumulate), chosen by a 2-bit mode select.
- Activation and arithmetic stages use it to evaluate trig, exponential, MAC and divide primitives on signed fixed-point operands.

Parameters:
- WIDTH, 15, MSB index of every data port; ports are WIDTH+1 = 16 bits, two's complement, Q5.10 (1024 = 1.0).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- ext_reset  input  1  synchronous, active-low reset.
- Xo  input  WIDTH+1  initial X operand, signed Q5.10.
- Yo  input  WIDTH+1  initial Y operand, signed Q5.10.
- Zo  input  WIDTH+1  initial Z operand (angle in radians or accumulator), signed Q5.10.
- sel  input  2  mode: 00 circular rotation, 01 hyperbolic rotation, 10 linear rotation, 11 linear vectoring.
- z  output  WIDTH+1  result, signed Q5.10, registered.

Behaviour:
- Reset (edge with ext_reset=0):
  - z=0, working registers x/y/a=0, iteration counter=0, state=LOAD.
  - Reset has priority over everything, including mid-computation: the operation is abandoned and z=0 on that edge.
- States: LOAD -> ITER -> DONE.
- LOAD (first edge with ext_reset=1): sample Xo, Yo, Zo and sel; sign-extend each into 20-bit internal registers (4 guard bits, same Q10 scaling); counter=0; go to ITER. z stays 0.
- ITER: exactly 16 edges, step k=0..15.
  - Shift s(k):
    - circular and linear: s=k.
    - hyperbolic: s = 1,2,3,4,4,5,6,7,8,9,10,11,12,13,13,14 (steps 4 and 13 repeated).
  - Direction d:
    - rotation modes: d=+1 if a>=0, else -1.
    - vectoring: d=+1 if x*y<0 (sign XOR), else -1.
  - Circular update: x'=x-d*(y>>>s); y'=y+d*(x>>>s); a'=a-d*atan(2^-s).
  - Hyperbolic update: x'=x+d*(y>>>s); y'=y+d*(x>>>s); a'=a-d*atanh(2^-s).
  - Linear update: x'=x; y'=y+d*(x>>>s); a'=a-d*2^-s.
  - All shifts are arithmetic.
  - Constant ROMs, Q10 rounded to nearest, indexed by s:
    - atan: 804,475,251,127,64,32,16,8,4,2,1, then 0.
    - atanh (s>=1): 562,262,129,64,32,16,8,4,2,1, then 0.
    - linear: 1024>>s.
  - After step 15 go to DONE.
- DONE (next edge), result selection:
  - sel 00: z = (x*622)>>>10, i.e. gain-compensated Xo*cos(Zo) - Yo*sin(Zo).
  - sel 01: z = (x*1236)>>>10, i.e. Xo*cosh(Zo) + Yo*sinh(Zo).
  - sel 10: z = y, i.e. Yo + Xo*Zo.
  - sel 11: z = a, i.e. Zo + Yo/Xo.
  - Result is saturated to the 16-bit range [-32768, 32767].
  - Remain in DONE holding z until reset.
- Latency: result appears 18 rising edges after the first edge with ext_reset=1 (LOAD + 16 ITER + DONE). z reads 0 throughout computation.
- sel, Xo, Yo and Zo changes after LOAD are ignored until the next reset.
- Convergence ranges:
  - circular: |Zo| <= 1.74 rad.
  - hyperbolic: |Zo| <= 1.11.
  - linear rotation: |Zo| < 2.
  - vectoring: |Yo/Xo| < 2.
  - Outside these ranges the output is defined by the algorithm above (no error flag).
- Accuracy inside range: within ±4 LSB of the ideal real-valued result.

Test Plan:
- Reset/latency: hold ext_reset=0 two cycles, release with sel=10, Xo=128, Yo=-512, Zo=1024 -> z=0 for 17 edges, z=-384±4 on edge 18, held thereafter.
- Circular: sel=00, Xo=1024, Yo=0, Zo=536 (≈π/6) -> z≈887±4; with Zo=0 -> z≈1024±4.
- Hyperbolic: sel=01, Xo=Yo=512, Zo=512 -> z≈844±4 (0.5·e^0.5); with Zo=0 -> z≈512±4.
- Vectoring: sel=11, Xo=64, Yo=-64, Zo=288 -> z≈-736±4; Xo=512, Yo=256, Zo=0 -> z≈512±4.
- Reset mid-operation: start sel=10 run, drive ext_reset=0 at iteration 8 -> z=0 on that edge. Release with new operands Xo=512, Yo=0, Zo=512 -> z=256±4 exactly 18 edges later, no residue from the aborted run.
- Saturation: sel=10, Xo=Yo=32767, Zo=1536 -> z=32767.
